// File: rtl/full_st1_in_seq.sv
// full_st1_in_seq: input sequencer that feeds the first fully-connected stage.
// Input frames of NIN words arrive on a valid/ready stream. They are stored in
// a two-bank ping-pong buffer and replayed as gap-free serial bursts. At least
// GAP idle cycles separate two bursts so the stage's delay line can drain.
//
// Ports
//   clk                   clock
//   reset                 asynchronous reset, active low
//   in_valid/in_ready     input handshake; in_ready is registered
//   in_data               input word (float_24_8 packed)
//   in_last               marks the final word of a frame
//   in_mode               error-mode flag, sampled with word 0 of a frame
//   out_valid             out_data valid (one burst of NIN words)
//   out_data              serial word to the stage, 0 when out_valid=0
//   out_first             pulse on word 0 of a burst
//   out_stage_error_mode  frame's error-mode flag, held for the whole burst
//   out_stage_error_first out_first AND error mode
//   busy                  a bank is full, a burst/gap is running, or a frame is partially written
//   err_len               sticky frame-length error
module full_st1_in_seq #(
  parameter int NIN   = 6,
  parameter int GAP   = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_first,
  output logic             out_stage_error_mode,
  output logic             out_stage_error_first,
  output logic             busy,
  output logic             err_len
);

  localparam int CW = $clog2(NIN);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_e;

  logic [WIDTH-1:0] mem_q [2][NIN];
  logic [1:0]       full_q, full_d, mode_q;
  logic             wbank_q, wbank_d, rbank_q, rbank_d;
  logic [CW-1:0]    wcnt_q, wcnt_d, rcnt_q, rnext;
  logic [GW-1:0]    gcnt_q;
  state_e           state_q;
  logic             in_ready_q, err_q;
  logic             out_valid_q, out_first_q, out_mode_q, out_efirst_q;
  logic [WIDTH-1:0] out_data_q;
  logic             acc, commit, len_err, rel, can_start, start;

  // Write side: word placement, frame commit and length checking.
  always_comb begin
    acc     = in_valid && in_ready_q;
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    commit  = 1'b0;
    len_err = 1'b0;
    if (acc) begin
      if (wcnt_q == LAST_IDX) begin
        // A full-length frame commits even without in_last, but is flagged.
        commit  = 1'b1;
        wbank_d = ~wbank_q;
        wcnt_d  = '0;
        len_err = ~in_last;
      end else if (in_last) begin
        // Short frame: drop it, the bank stays free for the next frame.
        wcnt_d  = '0;
        len_err = 1'b1;
      end else begin
        wcnt_d  = wcnt_q + 1'b1;
      end
    end
  end

  // Read side: release on the last burst word; a new burst may start from
  // IDLE, at the end of the gap, or straight after a burst when GAP=0.
  always_comb begin
    rel       = (state_q == S_STREAM) && (rcnt_q == LAST_IDX);
    rbank_d   = rel ? ~rbank_q : rbank_q;
    can_start = (state_q == S_IDLE) ||
                ((state_q == S_GAP) && (gcnt_q == GAP_LAST)) ||
                (rel && (GAP == 0));
    start     = can_start && full_q[rbank_d];
    rnext     = rcnt_q + 1'b1;
    // Commit and release always hit different banks, so both are honoured.
    full_d    = full_q;
    if (commit) full_d[wbank_q] = 1'b1;
    if (rel)    full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wbank_q][wcnt_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      full_q       <= '0;
      mode_q       <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      gcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_first_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      out_efirst_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      wcnt_q     <= wcnt_d;
      rbank_q    <= rbank_d;
      in_ready_q <= ~full_d[wbank_d];
      err_q      <= err_q | len_err;
      if (acc && (wcnt_q == '0)) mode_q[wbank_q] <= in_mode;

      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_first_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      out_efirst_q <= 1'b0;

      if (start) begin
        state_q      <= S_STREAM;
        rcnt_q       <= '0;
        out_valid_q  <= 1'b1;
        out_data_q   <= mem_q[rbank_d][0];
        out_first_q  <= 1'b1;
        out_mode_q   <= mode_q[rbank_d];
        out_efirst_q <= mode_q[rbank_d];
      end else begin
        unique case (state_q)
          S_STREAM: begin
            if (rel) begin
              state_q <= (GAP > 0) ? S_GAP : S_IDLE;
              gcnt_q  <= '0;
            end else begin
              rcnt_q      <= rnext;
              out_valid_q <= 1'b1;
              out_data_q  <= mem_q[rbank_q][rnext];
              out_mode_q  <= mode_q[rbank_q];
            end
          end
          S_GAP: begin
            if (gcnt_q == GAP_LAST) state_q <= S_IDLE;
            else                    gcnt_q  <= gcnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready              = in_ready_q;
  assign out_valid             = out_valid_q;
  assign out_data              = out_data_q;
  assign out_first             = out_first_q;
  assign out_stage_error_mode  = out_mode_q;
  assign out_stage_error_first = out_efirst_q;
  assign err_len               = err_q;
  assign busy                  = (|full_q) || (state_q != S_IDLE) || (wcnt_q != '0);

endmodule
